// File: rtl/rx_syn_pkg.sv
// Shared types, widths and default thresholds for the receive-sync sequencer.
package rx_syn_pkg;

  localparam int TIMER_W = 20;
  localparam int RETRY_W = 4;
  localparam int MISS_W  = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_FINE   = 3'd2,
    ST_TRACK  = 3'd3
  } syn_state_e;

  localparam logic [2:0] DEF_THRESH_NORM  = 3'd3;
  localparam logic [2:0] DEF_THRESH_RELAX = 3'd2;

  // The miss counter holds at all-ones rather than wrapping back to zero.
  function automatic logic [MISS_W-1:0] miss_sat_inc(input logic [MISS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rx_syn_ctrl_if.sv
// Handshake bundle between the sync sequencer and the coarse/fine sync blocks.
interface rx_syn_ctrl_if;
  import rx_syn_pkg::*;

  logic               rx_enable_in;
  logic               coarse_syn_success_in;
  logic               fine_syn_done_in;
  logic               fine_syn_fail_in;
  logic               slot_tick_in;
  logic               slot_hit_in;
  logic               coarse_search_en_out;
  logic [2:0]         threshold_out;
  logic               fine_syn_start_out;
  logic               syn_locked_out;
  logic               lock_lost_out;
  logic               search_fail_out;
  logic [2:0]         syn_state_out;
  logic [RETRY_W-1:0] retry_cnt_out;

  modport master (
    input  rx_enable_in, coarse_syn_success_in, fine_syn_done_in,
           fine_syn_fail_in, slot_tick_in, slot_hit_in,
    output coarse_search_en_out, threshold_out, fine_syn_start_out,
           syn_locked_out, lock_lost_out, search_fail_out,
           syn_state_out, retry_cnt_out
  );

  modport slave (
    output rx_enable_in, coarse_syn_success_in, fine_syn_done_in,
           fine_syn_fail_in, slot_tick_in, slot_hit_in,
    input  coarse_search_en_out, threshold_out, fine_syn_start_out,
           syn_locked_out, lock_lost_out, search_fail_out,
           syn_state_out, retry_cnt_out
  );

endinterface

// File: rtl/rx_syn_timer.sv
// Clearable saturating attempt timer with an expire flag at a programmable limit.
// The raw count is only exported when RX_SYN_DEBUG_EN is defined.
module rx_syn_timer
  import rx_syn_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic [TIMER_W-1:0] limit_i,
`ifdef RX_SYN_DEBUG_EN
  output logic [TIMER_W-1:0] count_o,
`endif
  output logic               expire_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef RX_SYN_DEBUG_EN
  assign count_o = count_q;
`endif
  assign expire_o = (count_q == limit_i);

endmodule

// File: rtl/rx_syn_ctrl.sv
// Receive-sync sequencer: coarse search, fine sync, lock tracking, retries.
// Define RX_SYN_DEBUG_EN to populate debug_signal; otherwise it is tied to zero.
module rx_syn_ctrl
  import rx_syn_pkg::*;
#(
  parameter logic [TIMER_W-1:0] COARSE_TIMEOUT = 20'd96000,
  parameter logic [TIMER_W-1:0] FINE_TIMEOUT   = 20'd20800,
  parameter logic [RETRY_W-1:0] MAX_RETRY      = 4'd4,
  parameter logic [MISS_W-1:0]  MISS_LIMIT     = 6'd8,
  parameter logic [2:0]         THRESH_NORM    = DEF_THRESH_NORM,
  parameter logic [2:0]         THRESH_RELAX   = DEF_THRESH_RELAX
) (
  input  logic                logic_clk_in,
  input  logic                logic_rst_in,
  rx_syn_ctrl_if.master       bus,
  output logic [63:0]         debug_signal
);

  syn_state_e         state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [MISS_W-1:0]  miss_q, miss_d, miss_inc;
  logic               timer_clear, timer_expire, attempt_fail;
  logic [TIMER_W-1:0] timer_limit;
  logic               fine_start_d, lock_lost_d, search_fail_d;

  logic               coarse_en_q, fine_start_q, locked_q, lock_lost_q, search_fail_q;
  logic [2:0]         threshold_q;

  // One timer serves both attempt phases; only its limit changes with state.
  assign timer_limit = (state_q == ST_FINE) ? FINE_TIMEOUT - 1'b1 : COARSE_TIMEOUT - 1'b1;
  assign miss_inc    = miss_sat_inc(miss_q);

`ifdef RX_SYN_DEBUG_EN
  logic [TIMER_W-1:0] timer_cnt;
`endif

  rx_syn_timer u_timer (
    .clk_i    (logic_clk_in),
    .rst_i    (logic_rst_in),
    .clear_i  (timer_clear),
    .limit_i  (timer_limit),
`ifdef RX_SYN_DEBUG_EN
    .count_o  (timer_cnt),
`endif
    .expire_o (timer_expire)
  );

  always_comb begin
    state_d       = state_q;
    retry_d       = retry_q;
    miss_d        = miss_q;
    timer_clear   = 1'b0;
    attempt_fail  = 1'b0;
    fine_start_d  = 1'b0;
    lock_lost_d   = 1'b0;
    search_fail_d = 1'b0;

    if (!bus.rx_enable_in) begin
      state_d     = ST_IDLE;
      retry_d     = '0;
      miss_d      = '0;
      timer_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d     = ST_SEARCH;
          retry_d     = '0;
          miss_d      = '0;
          timer_clear = 1'b1;
        end
        ST_SEARCH: begin
          // A success landing on the timeout cycle still counts as success.
          if (bus.coarse_syn_success_in) begin
            state_d      = ST_FINE;
            timer_clear  = 1'b1;
            fine_start_d = 1'b1;
          end else if (timer_expire) begin
            attempt_fail = 1'b1;
          end
        end
        ST_FINE: begin
          if (bus.fine_syn_done_in) begin
            state_d     = ST_TRACK;
            retry_d     = '0;
            miss_d      = '0;
            timer_clear = 1'b1;
          end else if (bus.fine_syn_fail_in || timer_expire) begin
            attempt_fail = 1'b1;
          end
        end
        ST_TRACK: begin
          timer_clear = 1'b1;
          if (bus.slot_tick_in) begin
            if (bus.slot_hit_in) begin
              miss_d = '0;
            end else if (miss_inc == MISS_LIMIT) begin
              state_d     = ST_SEARCH;
              retry_d     = '0;
              miss_d      = '0;
              lock_lost_d = 1'b1;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          retry_d     = '0;
          miss_d      = '0;
          timer_clear = 1'b1;
        end
      endcase

      // Coarse and fine failures draw on the same retry budget.
      if (attempt_fail) begin
        timer_clear = 1'b1;
        if (retry_q >= MAX_RETRY - 1'b1) begin
          state_d       = ST_IDLE;
          retry_d       = '0;
          search_fail_d = 1'b1;
        end else begin
          state_d = ST_SEARCH;
          retry_d = retry_q + 1'b1;
        end
      end
    end
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge logic_clk_in) begin
    if (logic_rst_in) begin
      state_q       <= ST_IDLE;
      retry_q       <= '0;
      miss_q        <= '0;
      coarse_en_q   <= 1'b0;
      threshold_q   <= THRESH_NORM;
      fine_start_q  <= 1'b0;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
      search_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      miss_q        <= miss_d;
      coarse_en_q   <= (state_d == ST_SEARCH);
      threshold_q   <= (retry_d == '0) ? THRESH_NORM : THRESH_RELAX;
      fine_start_q  <= fine_start_d;
      locked_q      <= (state_d == ST_TRACK);
      lock_lost_q   <= lock_lost_d;
      search_fail_q <= search_fail_d;
    end
  end

  assign bus.coarse_search_en_out = coarse_en_q;
  assign bus.threshold_out        = threshold_q;
  assign bus.fine_syn_start_out   = fine_start_q;
  assign bus.syn_locked_out       = locked_q;
  assign bus.lock_lost_out        = lock_lost_q;
  assign bus.search_fail_out      = search_fail_q;
  assign bus.syn_state_out        = state_q;
  assign bus.retry_cnt_out        = retry_q;

`ifdef RX_SYN_DEBUG_EN
  logic [63:0] debug_q;

  always_ff @(posedge logic_clk_in) begin
    if (logic_rst_in) begin
      debug_q <= '0;
    end else begin
      debug_q <= {27'd0, bus.slot_hit_in, bus.fine_syn_fail_in, bus.fine_syn_done_in,
                  bus.coarse_syn_success_in, timer_cnt, miss_q, retry_q, state_q};
    end
  end

  assign debug_signal = debug_q;
`else
  assign debug_signal = 64'd0;
`endif

endmodule

// File: doc/rx_syn_ctrl.md
Name: rx_syn_ctrl

Overview:
- Receive-synchronisation sequencer sitting above the coarse-sync statistics block and the fine-sync correlator.
- Enables and configures the coarse search (decision threshold), and starts fine sync on the coarse success pulse.
- Declares lock, then supervises tracking hits per slot; falls back to search on loss.
- Applies timeouts and a bounded retry budget; declares search failure when the budget is exhausted.

Parameters:
- COARSE_TIMEOUT, 20'd96000, cycles allowed per coarse search attempt (must be >= 2)
- FINE_TIMEOUT, 20'd20800, cycles allowed for fine sync after coarse success (must be >= 2)
- MAX_RETRY, 4'd4, total attempts before giving up (must be >= 1)
- MISS_LIMIT, 6'd8, consecutive missed slots in TRACK before lock loss (must be >= 1)
- THRESH_NORM, 3'd3, coarse threshold on first attempt
- THRESH_RELAX, 3'd2, coarse threshold on retries

Ports:
- logic_clk_in  in  1  200 MHz logic clock
- logic_rst_in  in  1  synchronous, active-high reset
- rx_enable_in  in  1  level; receive chain enabled
- coarse_syn_success_in  in  1  1-cycle pulse from coarse statistics
- fine_syn_done_in  in  1  1-cycle pulse; fine sync achieved
- fine_syn_fail_in  in  1  1-cycle pulse; fine sync rejected
- slot_tick_in  in  1  1-cycle pulse per tracking slot
- slot_hit_in  in  1  correlation hit, sampled only when slot_tick_in=1
- coarse_search_en_out  out  1  enables coarse correlation/statistics
- threshold_out  out  3  threshold for coarse statistics
- fine_syn_start_out  out  1  1-cycle pulse; start fine sync
- syn_locked_out  out  1  level; high only in TRACK
- lock_lost_out  out  1  1-cycle pulse on TRACK->SEARCH
- search_fail_out  out  1  1-cycle pulse when the retry budget is exhausted
- syn_state_out  out  3  current state encoding
- retry_cnt_out  out  4  attempts consumed
- debug_signal  out  64  debug bus

Behaviour:
- One clock (logic_clk_in). Reset is synchronous and active-high (logic_rst_in). All outputs are registered.
- Reset values: state IDLE, all outputs 0, threshold_out=THRESH_NORM, timer/retry/miss counters 0.
- State encodings: IDLE=0, SEARCH=1, FINE=2, TRACK=3.
- Priority: reset > rx_enable_in=0 (any state -> IDLE next cycle, counters cleared, no pulses) > state logic.
- IDLE:
  - rx_enable_in=1 -> SEARCH.
  - timer=0, retry=0.
- SEARCH:
  - coarse_search_en_out=1.
  - threshold_out=THRESH_NORM if retry=0, else THRESH_RELAX.
  - timer increments by 1 per cycle.
  - coarse_syn_success_in=1 -> FINE. fine_syn_start_out=1 in the first FINE cycle, timer=0, coarse_search_en_out=0 from that cycle.
  - If timer==COARSE_TIMEOUT-1 and no success, an attempt fails:
    - if retry==MAX_RETRY-1 -> IDLE, search_fail_out pulse;
    - otherwise stay in SEARCH, retry+1, timer=0.
  - Success in the same cycle as timeout: success wins.
- FINE:
  - timer increments by 1 per cycle.
  - fine_syn_done_in -> TRACK. syn_locked_out=1 from the first TRACK cycle; retry=0; miss=0.
  - fine_syn_fail_in, or timer==FINE_TIMEOUT-1, is a failed attempt under the same retry rule; the non-exhausted case re-enters SEARCH with timer=0.
  - done and fail in the same cycle: done wins.
  - coarse_syn_success_in is ignored in FINE.
- TRACK:
  - Counters are evaluated only on slot_tick_in=1: hit -> miss=0; no hit -> miss+1.
  - When the incremented miss value equals MISS_LIMIT -> SEARCH, with lock_lost_out pulse, syn_locked_out=0, retry=0, timer=0.
- Pulse latency is 1 cycle from the triggering input edge.
- Counters saturate and never wrap; timer width is 20 bits.

Optional Feature:
- Macro: RX_SYN_DEBUG_EN.
- Defined: debug_signal maps the following fields:
  - [2:0] state
  - [6:3] retry
  - [12:7] miss
  - [32:13] timer
  - [33] coarse_syn_success_in
  - [34] fine_syn_done_in
  - [35] fine_syn_fail_in
  - [36] slot_hit_in
  - [63:37] 0
- Undefined: debug_signal is tied to 64'd0 and the debug registers are not synthesised. Functional outputs are identical in both builds.

Decomposition:
- Package rx_syn_pkg holds:
  - state encodings
  - widths: TIMER_W=20, RETRY_W=4, MISS_W=6
  - default thresholds
- Sub-module rx_syn_timer: clearable, saturating 20-bit up-counter with an expire flag at a programmable limit. It is instantiated once and shared by SEARCH and FINE; the limit is muxed by state.

Test Plan:
- Bench parameters: COARSE_TIMEOUT=100, FINE_TIMEOUT=50, MAX_RETRY=3, MISS_LIMIT=4.
- Happy path: rx_enable_in=1; coarse success at cycle 20; fine done 10 cycles later -> fine_syn_start_out pulses once; syn_locked_out=1 one cycle after done; syn_state_out=3; threshold_out=3 throughout SEARCH.
- Coarse timeout: no success -> retry_cnt_out=1 at cycle 100 with threshold_out=2; after 300 cycles search_fail_out pulses once; state=0; coarse_search_en_out=0.
- Fine reject: success, then fine_syn_fail_in -> back to SEARCH with retry=1 and threshold_out=2; no lock.
- Lock loss: in TRACK, 3 ticks miss + 1 hit + 4 ticks miss -> lock_lost_out pulses exactly after the 8th tick; syn_locked_out=0; state=1; retry=0.
- Collisions/abort: coarse success coincident with the timeout cycle -> FINE, retry unchanged. rx_enable_in dropped mid-FINE -> IDLE next cycle, no pulses. logic_rst_in mid-TRACK -> all outputs 0 next cycle.
